matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
Sequencer for single-precision floating-point matrix multiply C = A x B over the shared vector memory.
- Fetches the two-word headers {rows, cols} of A and B.
- Checks dimensions, writes C's header, then walks i (row of A), j (column of B) and k (inner index) as registered counters.
- Streams element pairs to an external FP multiply-accumulate unit over a valid/ready handshake, then writes each finished dot product back to C.
- Replaces free-running combinational index feedback with an explicit start/busy/done FSM.

Parameters:
- AW, 32, byte address width of the memory ports.
- DIM_W, 16, width of the i/j/k counters; header words above this width are an error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; ignored unless idle
- addr_a  in  AW  byte base of matrix A header (word 0 = rows, word 1 = cols, data from +8, row-major)
- addr_b  in  AW  byte base of matrix B header
- addr_c  in  AW  byte base of matrix C header
- rd_addr_a  out  AW  read address, port A (combinational-read memory)
- rd_data_a  in  32  read data, port A
- rd_addr_b  out  AW  read address, port B
- rd_data_b  in  32  read data, port B
- mem_we  out  1  write enable (memory writes on clk rising edge)
- mem_waddr  out  AW  write address
- mem_wdata  out  32  write data
- mac_valid  out  1  operand pair valid
- mac_ready  in  1  MAC accepts pair
- mac_first  out  1  pair is k=0; MAC clears its accumulator
- mac_last  out  1  pair is k=K-1
- mac_opa  out  32  A[i][k]
- mac_opb  out  32  B[k][j]
- acc_valid  in  1  one-cycle pulse, dot product ready
- acc_data  in  32  dot product
- busy  out  1  high from the cycle after an accepted start until done/error
- done  out  1  one-cycle pulse, C complete
- error  out  1  one-cycle pulse, bad dimensions

Behaviour:
- Reset (async, any state) values: state IDLE, all counters 0, busy/done/error/mac_valid/mac_first/mac_last/mem_we 0, all addresses 0. Reset mid-operation aborts with no further writes. C may be partially written; that is acceptable.
- Base addresses are latched on the accepted start. Later changes to addr_* are ignored.
- IDLE: on start go to HDR, registering M, K, N, Kb.
- HDR (1 cycle): drive rd_addr_a=addr_a, rd_addr_b=addr_b, register M=A.rows and Kb=B.rows. Then HDR2: addr_*+4, register K=A.cols and N=B.cols.
- CHECK: error if any of M, K, N is 0, if K != Kb, or if any header word ≥ 2^DIM_W. On error: pulse error, go to IDLE, no memory writes. Otherwise go to WHDR.
- WHDR (2 cycles): write M to addr_c, then N to addr_c+4. Clear i, j, k. Go to ISSUE.
- ISSUE: drive rd_addr_a=pa and rd_addr_b=pb, and present rd_data on mac_opa/mac_opb with mac_valid=1.
  - mac_first=(k==0), mac_last=(k==K-1).
  - Operands and flags hold stable while mac_ready=0.
  - On valid&&ready: k++, pa+=4, pb+=4*N.
  - After the k=K-1 transfer go to WAIT.
- Pointers are maintained incrementally; no multiplier.
  - pa = addr_a+8+4*(i*K+k)
  - pb = addr_b+8+4*(k*N+j)
  - pc = addr_c+8+4*(i*N+j)
- WAIT: mac_valid=0. On acc_valid, write acc_data to pc with mem_we for 1 cycle. In the same cycle, advance:
  - j++, pc+=4.
  - If j wraps at N: j=0, i++.
  - k=0. pa rewinds to row i start; pb rewinds to addr_b+8+4*j.
  - If i wraps at M: go to DONE, else ISSUE.
  - An acc_valid arriving in any other state is ignored.
- DONE: pulse done 1 cycle, busy drops the same cycle, then IDLE.
- start while busy is ignored.
- Counter widths: DIM_W. Address arithmetic is modulo 2^AW.
- Throughput: 1 pair/cycle when mac_ready=1. Bubble between dot products = MAC latency + 1.

Decomposition:
- Shared package `matmul_pkg`:
  - state enum
  - HDR_BYTES=8, WORD_BYTES=4
  - FP32 width constant
- One natural sub-module, `matmul_addr_gen`: i/j/k counters plus pa/pb/pc incremental pointer update, driven by `step_k` / `step_ij` strobes, with wrap flags out. The FSM stays in the top.

Test Plan:
1. 2x3 * 3x2 integer-valued floats (A=1..6, B=7..12), MAC ready always, 3-cycle latency -> C header {2,2}, C=[58,64,139,154] at addr_c+8..+20, done once, 4 data writes + 2 header writes.
2. 1x1 * 1x1 (A=2.0, B=3.0) -> mac_first=mac_last=1 on the single pair; C[0]=6.0; done.
3. A 2x3, B 2x2 (K mismatch) -> error pulse after CHECK, zero mem_we cycles, busy low afterwards.
4. Random mac_ready stalls on case 1 -> identical C; mac_opa/mac_opb/flags stable during every stall cycle.
5. Assert reset mid-ISSUE of case 1, then restart -> all outputs 0 immediately; second run completes correctly.
6. start pulsed again while busy in case 1 -> ignored; exactly one done.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
// FSM state encoding, header/word byte sizes and the FP32 word width.
package matmul_pkg;

  localparam int unsigned HDR_BYTES  = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned FP_W       = 32;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_HDR2,
    S_CHECK,
    S_WHDR1,
    S_WHDR2,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/matmul_addr_gen.sv
// i/j/k counters and incremental element pointers for C = A x B.
// Ports: init_i loads bases, step_k_i advances k, step_ij_i finishes a
// dot product (advances j/i, rewinds k); pa/pb/pc_o and wrap flags out.
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic             step_k_i,
  input  logic             step_ij_i,
  input  logic [AW-1:0]    base_a_i,
  input  logic [AW-1:0]    base_b_i,
  input  logic [AW-1:0]    base_c_i,
  input  logic [DIM_W-1:0] dim_m_i,
  input  logic [DIM_W-1:0] dim_k_i,
  input  logic [DIM_W-1:0] dim_n_i,
  output logic [AW-1:0]    pa_o,
  output logic [AW-1:0]    pb_o,
  output logic [AW-1:0]    pc_o,
  output logic             k_first_o,
  output logic             k_last_o,
  output logic             j_wrap_o,
  output logic             i_wrap_o
);

  logic [DIM_W-1:0] i_q, i_d;
  logic [DIM_W-1:0] j_q, j_d;
  logic [DIM_W-1:0] k_q, k_d;
  logic [AW-1:0]    pa_q, pa_d;
  logic [AW-1:0]    pb_q, pb_d;
  logic [AW-1:0]    pc_q, pc_d;
  // row_a: start of row i of A; col_b: start of column j of B
  logic [AW-1:0]    row_a_q, row_a_d;
  logic [AW-1:0]    col_b_q, col_b_d;

  logic [AW-1:0]    stride_a;
  logic [AW-1:0]    stride_b;
  logic [AW-1:0]    word;
  logic [AW-1:0]    hdr;

  assign word     = AW'(WORD_BYTES);
  assign hdr      = AW'(HDR_BYTES);
  assign stride_a = AW'(dim_k_i) << 2;
  assign stride_b = AW'(dim_n_i) << 2;

  assign k_first_o = (k_q == '0);
  assign k_last_o  = (k_q == dim_k_i - DIM_W'(1));
  assign j_wrap_o  = (j_q == dim_n_i - DIM_W'(1));
  assign i_wrap_o  = (i_q == dim_m_i - DIM_W'(1));

  assign pa_o = pa_q;
  assign pb_o = pb_q;
  assign pc_o = pc_q;

  always_comb begin
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    pc_d    = pc_q;
    row_a_d = row_a_q;
    col_b_d = col_b_q;
    if (init_i) begin
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      row_a_d = base_a_i + hdr;
      col_b_d = base_b_i + hdr;
      pa_d    = base_a_i + hdr;
      pb_d    = base_b_i + hdr;
      pc_d    = base_c_i + hdr;
    end else if (step_ij_i) begin
      k_d  = '0;
      pc_d = pc_q + word;
      if (j_wrap_o) begin
        j_d     = '0;
        i_d     = i_wrap_o ? '0 : i_q + DIM_W'(1);
        row_a_d = row_a_q + stride_a;
        col_b_d = base_b_i + hdr;
      end else begin
        j_d     = j_q + DIM_W'(1);
        col_b_d = col_b_q + word;
      end
      pa_d = row_a_d;
      pb_d = col_b_d;
    end else if (step_k_i) begin
      k_d  = k_q + DIM_W'(1);
      pa_d = pa_q + word;
      pb_d = pb_q + stride_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
      pc_q    <= '0;
      row_a_q <= '0;
      col_b_q <= '0;
    end else begin
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      pc_q    <= pc_d;
      row_a_q <= row_a_d;
      col_b_q <= col_b_d;
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Start/busy/done sequencer for FP32 C = A x B over shared memory.
// Ports: start + base addresses in; two read ports, one write port,
// MAC operand stream (valid/ready) and dot-product return; status out.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DIM_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   addr_a,
  input  logic [AW-1:0]   addr_b,
  input  logic [AW-1:0]   addr_c,
  output logic [AW-1:0]   rd_addr_a,
  input  logic [31:0]     rd_data_a,
  output logic [AW-1:0]   rd_addr_b,
  input  logic [31:0]     rd_data_b,
  output logic            mem_we,
  output logic [AW-1:0]   mem_waddr,
  output logic [31:0]     mem_wdata,
  output logic            mac_valid,
  input  logic            mac_ready,
  output logic            mac_first,
  output logic            mac_last,
  output logic [FP_W-1:0] mac_opa,
  output logic [FP_W-1:0] mac_opb,
  input  logic            acc_valid,
  input  logic [FP_W-1:0] acc_data,
  output logic            busy,
  output logic            done,
  output logic            error
);

  state_e state_q, state_d;

  logic [AW-1:0] base_a_q, base_a_d;
  logic [AW-1:0] base_b_q, base_b_d;
  logic [AW-1:0] base_c_q, base_c_d;
  // full header words are kept so oversize dimensions can be flagged
  logic [31:0]   hm_q, hm_d;
  logic [31:0]   hk_q, hk_d;
  logic [31:0]   hkb_q, hkb_d;
  logic [31:0]   hn_q, hn_d;

  logic          init;
  logic          step_k;
  logic          step_ij;
  logic [AW-1:0] pa;
  logic [AW-1:0] pb;
  logic [AW-1:0] pc;
  logic          k_first;
  logic          k_last;
  logic          j_wrap;
  logic          i_wrap;
  logic          bad_dims;

  function automatic logic too_big(input logic [31:0] w);
    return (w >> DIM_W) != '0;
  endfunction

  assign bad_dims = (hm_q == '0) || (hk_q == '0) || (hn_q == '0) ||
                    (hk_q != hkb_q) ||
                    too_big(hm_q) || too_big(hk_q) ||
                    too_big(hkb_q) || too_big(hn_q);

  matmul_addr_gen #(
    .AW    (AW),
    .DIM_W (DIM_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (reset),
    .init_i    (init),
    .step_k_i  (step_k),
    .step_ij_i (step_ij),
    .base_a_i  (base_a_q),
    .base_b_i  (base_b_q),
    .base_c_i  (base_c_q),
    .dim_m_i   (hm_q[DIM_W-1:0]),
    .dim_k_i   (hk_q[DIM_W-1:0]),
    .dim_n_i   (hn_q[DIM_W-1:0]),
    .pa_o      (pa),
    .pb_o      (pb),
    .pc_o      (pc),
    .k_first_o (k_first),
    .k_last_o  (k_last),
    .j_wrap_o  (j_wrap),
    .i_wrap_o  (i_wrap)
  );

  always_comb begin
    state_d   = state_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    base_c_d  = base_c_q;
    hm_d      = hm_q;
    hk_d      = hk_q;
    hkb_d     = hkb_q;
    hn_d      = hn_q;
    rd_addr_a = '0;
    rd_addr_b = '0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mac_valid = 1'b0;
    mac_first = 1'b0;
    mac_last  = 1'b0;
    mac_opa   = '0;
    mac_opb   = '0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    init      = 1'b0;
    step_k    = 1'b0;
    step_ij   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          base_a_d = addr_a;
          base_b_d = addr_b;
          base_c_d = addr_c;
          hm_d     = '0;
          hk_d     = '0;
          hkb_d    = '0;
          hn_d     = '0;
          state_d  = S_HDR;
        end
      end
      S_HDR: begin
        rd_addr_a = base_a_q;
        rd_addr_b = base_b_q;
        hm_d      = rd_data_a;
        hkb_d     = rd_data_b;
        state_d   = S_HDR2;
      end
      S_HDR2: begin
        rd_addr_a = base_a_q + AW'(WORD_BYTES);
        rd_addr_b = base_b_q + AW'(WORD_BYTES);
        hk_d      = rd_data_a;
        hn_d      = rd_data_b;
        state_d   = S_CHECK;
      end
      S_CHECK: begin
        if (bad_dims) begin
          error   = 1'b1;
          busy    = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WHDR1;
        end
      end
      S_WHDR1: begin
        mem_we    = 1'b1;
        mem_waddr = base_c_q;
        mem_wdata = hm_q;
        state_d   = S_WHDR2;
      end
      S_WHDR2: begin
        mem_we    = 1'b1;
        mem_waddr = base_c_q + AW'(WORD_BYTES);
        mem_wdata = hn_q;
        init      = 1'b1;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        // pointers only move on a transfer, so operands hold while stalled
        rd_addr_a = pa;
        rd_addr_b = pb;
        mac_valid = 1'b1;
        mac_first = k_first;
        mac_last  = k_last;
        mac_opa   = rd_data_a;
        mac_opb   = rd_data_b;
        if (mac_ready) begin
          step_k = 1'b1;
          if (k_last) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (acc_valid) begin
          mem_we    = 1'b1;
          mem_waddr = pc;
          mem_wdata = acc_data;
          step_ij   = 1'b1;
          state_d   = (j_wrap && i_wrap) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        busy    = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      hm_q     <= '0;
      hk_q     <= '0;
      hkb_q    <= '0;
      hn_q     <= '0;
    end else begin
      state_q  <= state_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      hm_q     <= hm_d;
      hk_q     <= hk_d;
      hkb_q    <= hkb_d;
      hn_q     <= hn_d;
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl with a memory and MAC model.
// Expected pairs/writes are queued at stimulus time, checked by monitor.
module tb_matmul_seq_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] addr_a, addr_b, addr_c;
  logic [31:0] rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        mem_we;
  logic [31:0] mem_waddr, mem_wdata;
  logic        mac_valid, mac_ready, mac_first, mac_last;
  logic [31:0] mac_opa, mac_opb;
  logic        acc_valid;
  logic [31:0] acc_data;
  logic        busy, done, error;

  matmul_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .addr_c    (addr_c),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mac_valid (mac_valid),
    .mac_ready (mac_ready),
    .mac_first (mac_first),
    .mac_last  (mac_last),
    .mac_opa   (mac_opa),
    .mac_opb   (mac_opb),
    .acc_valid (acc_valid),
    .acc_data  (acc_data),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        f;
    logic        l;
  } pair_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  pair_t       pq[$];
  wr_t         wq[$];
  logic [31:0] mem [0:255];
  logic [31:0] fpv [0:12];
  int          n_vec = 0;
  int          n_miss = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          lat_cnt = 0;
  int          acc = 0;
  bit          ready_rand = 1'b0;

  assign rd_data_a = mem[rd_addr_a[9:2]];
  assign rd_data_b = mem[rd_addr_b[9:2]];

  always @(posedge clk)
    if (mem_we) mem[mem_waddr[9:2]] = mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int fp2int(input logic [31:0] f);
    int e;
    int m;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    m = int'({1'b1, f[22:0]});
    if (e >= 150) return m <<< (e - 150);
    return m >>> (150 - e);
  endfunction

  function automatic logic [31:0] int2fp(input int v);
    int          p;
    logic [31:0] t;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 31; b++)
      if (v[b]) p = b;
    t = 32'(v) << (31 - p);
    r = '0;
    r[30:23] = 8'(127 + p);
    r[22:0] = t[30:8];
    return r;
  endfunction

  // MAC ready generator
  always @(posedge clk) begin
    #1;
    mac_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // MAC result latency
  always @(posedge clk) begin
    #1;
    acc_valid = 1'b0;
    if (reset) lat_cnt = 0;
    else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        acc_valid = 1'b1;
        acc_data  = int2fp(acc);
      end
    end
  end

  // monitor: pairs, writes and status pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (mac_valid) begin
        if (pq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL pair_unexpected: got %h/%h expected none",
                   mac_opa, mac_opb);
        end else begin
          chk("mac_opa", mac_opa, pq[0].a);
          chk("mac_opb", mac_opb, pq[0].b);
          chk("mac_first", 32'(mac_first), 32'(pq[0].f));
          chk("mac_last", 32'(mac_last), 32'(pq[0].l));
          if (mac_ready) begin
            void'(pq.pop_front());
            if (mac_first)
              acc = fp2int(mac_opa) * fp2int(mac_opb);
            else
              acc = acc + fp2int(mac_opa) * fp2int(mac_opb);
            if (mac_last) lat_cnt = LAT;
          end
        end
      end
      if (mem_we) begin
        if (wq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL write_unexpected: got %h@%h expected none",
                   mem_wdata, mem_waddr);
        end else begin
          chk("wr_addr", mem_waddr, wq[0].addr);
          chk("wr_data", mem_wdata, wq[0].data);
          void'(wq.pop_front());
        end
      end
      if (done) done_cnt++;
      if (error) err_cnt++;
    end
  end

  task automatic push_w(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  task automatic push_p(input logic [31:0] a, input logic [31:0] b,
                        input logic f, input logic l);
    pair_t p;
    p.a = a;
    p.b = b;
    p.f = f;
    p.l = l;
    pq.push_back(p);
  endtask

  // case 1: A 2x3 = 1..6 at 0x000, B 3x2 = 7..12 at 0x100, C at 0x200
  task automatic push_case1();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < 3; k++)
          push_p(fpv[1 + i*3 + k], fpv[7 + k*2 + j], k == 0, k == 2);
    push_w(32'h200, 32'd2);
    push_w(32'h204, 32'd2);
    push_w(32'h208, 32'h42680000);
    push_w(32'h20C, 32'h42800000);
    push_w(32'h210, 32'h430B0000);
    push_w(32'h214, 32'h431A0000);
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c);
    @(posedge clk);
    #1;
    addr_a = a;
    addr_b = b;
    addr_c = c;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input string nm, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] c,
                     input int exp_done, input int exp_err,
                     input bit poke);
    int  d0;
    int  e0;
    bit  seen;
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start(a, b, c);
    if (poke) begin
      repeat (4) @(posedge clk);
      #1;
      addr_a = 32'h000;
      addr_b = 32'h180;
      addr_c = 32'h300;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      addr_a = 32'h3F0;
      addr_b = 32'h3F0;
      addr_c = 32'h3F0;
    end
    seen = 1'b0;
    for (int c2 = 0; c2 < 500 && !seen; c2++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0 || err_cnt != e0) seen = 1'b1;
    end
    chk({nm, "_finished"}, 32'(seen), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    chk({nm, "_done_cnt"}, 32'(done_cnt - d0), 32'(exp_done));
    chk({nm, "_err_cnt"}, 32'(err_cnt - e0), 32'(exp_err));
    chk({nm, "_pairs_left"}, 32'(pq.size()), 32'd0);
    chk({nm, "_writes_left"}, 32'(wq.size()), 32'd0);
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit hit;
    reset  = 1'b1;
    start  = 1'b0;
    addr_a = '0;
    addr_b = '0;
    addr_c = '0;
    mac_ready = 1'b1;
    acc_valid = 1'b0;
    acc_data  = '0;
    fpv[0]  = 32'h00000000;
    fpv[1]  = 32'h3F800000;
    fpv[2]  = 32'h40000000;
    fpv[3]  = 32'h40400000;
    fpv[4]  = 32'h40800000;
    fpv[5]  = 32'h40A00000;
    fpv[6]  = 32'h40C00000;
    fpv[7]  = 32'h40E00000;
    fpv[8]  = 32'h41000000;
    fpv[9]  = 32'h41100000;
    fpv[10] = 32'h41200000;
    fpv[11] = 32'h41300000;
    fpv[12] = 32'h41400000;
    for (int w = 0; w < 256; w++) mem[w] = '0;
    // A 2x3 at word 0, B 3x2 at word 64
    mem[0] = 32'd2;
    mem[1] = 32'd3;
    for (int n = 0; n < 6; n++) mem[2 + n] = fpv[1 + n];
    mem[64] = 32'd3;
    mem[65] = 32'd2;
    for (int n = 0; n < 6; n++) mem[66 + n] = fpv[7 + n];
    // 1x1 A=2.0 at word 16, 1x1 B=3.0 at word 80
    mem[16] = 32'd1;
    mem[17] = 32'd1;
    mem[18] = fpv[2];
    mem[80] = 32'd1;
    mem[81] = 32'd1;
    mem[82] = fpv[3];
    // 2x2 B at word 96 (K mismatch with A 2x3)
    mem[96] = 32'd2;
    mem[97] = 32'd2;
    // oversize rows at word 32, zero rows at word 40
    mem[32] = 32'h00010000;
    mem[33] = 32'd1;
    mem[40] = 32'd0;
    mem[41] = 32'd1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_mac_valid", 32'(mac_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rd_addr_a", rd_addr_a, 32'd0);
    reset = 1'b0;

    push_case1();
    run("case1", 32'h000, 32'h100, 32'h200, 1, 0, 1'b0);

    push_p(fpv[2], fpv[3], 1'b1, 1'b1);
    push_w(32'h280, 32'd1);
    push_w(32'h284, 32'd1);
    push_w(32'h288, 32'h40C00000);
    run("case2", 32'h040, 32'h140, 32'h280, 1, 0, 1'b0);

    run("kmismatch", 32'h000, 32'h180, 32'h300, 0, 1, 1'b0);
    run("oversize", 32'h080, 32'h140, 32'h300, 0, 1, 1'b0);
    run("zerodim", 32'h0A0, 32'h140, 32'h300, 0, 1, 1'b0);

    ready_rand = 1'b1;
    push_case1();
    run("stall", 32'h000, 32'h100, 32'h200, 1, 0, 1'b0);

    push_case1();
    run("restart_busy", 32'h000, 32'h100, 32'h200, 1, 0, 1'b1);
    ready_rand = 1'b0;

    push_case1();
    pulse_start(32'h000, 32'h100, 32'h200);
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (mac_valid) hit = 1'b1;
    end
    chk("reach_issue", 32'(hit), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    pq.delete();
    wq.delete();
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mac_valid", 32'(mac_valid), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_rd_addr_a", rd_addr_a, 32'd0);
    chk("abort_rd_addr_b", rd_addr_b, 32'd0);
    chk("abort_mac_opa", mac_opa, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push_case1();
    run("after_reset", 32'h000, 32'h100, 32'h200, 1, 0, 1'b0);

    chk("c_final_0", mem[130], 32'h42680000);
    chk("c_final_3", mem[133], 32'h431A0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
